// File: rtl/mcs4_timing_sequencer_pkg.sv
// rtl/mcs4_timing_sequencer_pkg.sv - shared slot constants, phase defaults and state types
package mcs4_timing_sequencer_pkg;

    localparam int SLOT_A1 = 0;
    localparam int SLOT_A2 = 1;
    localparam int SLOT_A3 = 2;
    localparam int SLOT_M1 = 3;
    localparam int SLOT_M2 = 4;
    localparam int SLOT_X1 = 5;
    localparam int SLOT_X2 = 6;
    localparam int SLOT_X3 = 7;

    localparam int DEF_NUM_SLOTS = 8;
    localparam int DEF_PH1_CYC   = 2;
    localparam int DEF_PH2_CYC   = 2;
    localparam int DEF_GAP_CYC   = 1;

    typedef enum logic {
        PH_IDLE = 1'b0,
        PH_RUN  = 1'b1
    } phase_state_e;

    // One sysclk period of the two-phase clock: each phase is followed by its own gap.
    function automatic int period_of(input int ph1, input int ph2, input int gap);
        return ph1 + gap + ph2 + gap;
    endfunction

endpackage

// File: rtl/mcs4_timing_sequencer_if.sv
// rtl/mcs4_timing_sequencer_if.sv - control inputs and timing outputs of the sequencer
interface mcs4_timing_sequencer_if #(
    parameter int NUM_SLOTS = 8
);
    localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    logic                 enable;
    logic                 slave_mode;
    logic                 sync_in;
    logic                 clk1;
    logic                 clk2;
    logic [NUM_SLOTS-1:0] slot;
    logic [IDX_W-1:0]     slot_idx;
    logic                 sync_out;
    logic                 locked;
    logic                 resync_err;

    modport master (
        input  enable, slave_mode, sync_in,
        output clk1, clk2, slot, slot_idx, sync_out, locked, resync_err
    );

    modport slave (
        output enable, slave_mode, sync_in,
        input  clk1, clk2, slot, slot_idx, sync_out, locked, resync_err
    );

endinterface

// File: rtl/mcs4_timing_sequencer_clock_phase_gen.sv
// rtl/mcs4_timing_sequencer_clock_phase_gen.sv - IDLE/RUN control, position counter and clk1/clk2 generation
module clock_phase_gen
    import mcs4_timing_sequencer_pkg::*;
#(
    parameter int PH1_CYC = DEF_PH1_CYC,
    parameter int PH2_CYC = DEF_PH2_CYC,
    parameter int GAP_CYC = DEF_GAP_CYC
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_enable,
    output logic o_clk1,
    output logic o_clk2,
    output logic o_period_end,
    output logic o_run
);

    localparam int PERIOD = period_of(PH1_CYC, PH2_CYC, GAP_CYC);
    localparam int P_W    = $clog2(PERIOD);

    localparam logic [P_W-1:0] P_PH1_END = P_W'(PH1_CYC - 1);
    localparam logic [P_W-1:0] P_PH2_BEG = P_W'(PH1_CYC + GAP_CYC);
    localparam logic [P_W-1:0] P_PH2_END = P_W'(PH1_CYC + GAP_CYC + PH2_CYC - 1);
    localparam logic [P_W-1:0] P_LAST    = P_W'(PERIOD - 1);

    generate
        if (PH1_CYC < 1) begin : g_bad_ph1
            $error("PH1_CYC must be >= 1");
        end
        if (PH2_CYC < 1) begin : g_bad_ph2
            $error("PH2_CYC must be >= 1");
        end
        if (GAP_CYC < 1) begin : g_bad_gap
            $error("GAP_CYC must be >= 1");
        end
    endgenerate

    phase_state_e   r_state;
    logic [P_W-1:0] r_p;
    logic           r_clk1;
    logic           r_clk2;
    logic           r_period_end;
    logic [P_W-1:0] w_p_next;

    always_comb begin
        w_p_next = r_p + P_W'(1);
    end

    // Outputs are decoded from the position being entered so they line up with r_p.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= PH_IDLE;
            r_p          <= '0;
            r_clk1       <= 1'b0;
            r_clk2       <= 1'b0;
            r_period_end <= 1'b0;
        end else begin
            case (r_state)
                PH_IDLE: begin
                    if (i_enable) begin
                        r_state      <= PH_RUN;
                        r_p          <= '0;
                        r_clk1       <= 1'b1;
                        r_clk2       <= 1'b0;
                        r_period_end <= 1'b0;
                    end
                end
                PH_RUN: begin
                    if (r_period_end) begin
                        r_p          <= '0;
                        r_clk2       <= 1'b0;
                        r_period_end <= 1'b0;
                        if (i_enable) begin
                            r_clk1  <= 1'b1;
                        end else begin
                            r_state <= PH_IDLE;
                            r_clk1  <= 1'b0;
                        end
                    end else begin
                        r_p          <= w_p_next;
                        r_clk1       <= (w_p_next <= P_PH1_END);
                        r_clk2       <= (w_p_next >= P_PH2_BEG) && (w_p_next <= P_PH2_END);
                        r_period_end <= (w_p_next == P_LAST);
                    end
                end
                default: begin
                    r_state <= PH_IDLE;
                    r_p     <= '0;
                    r_clk1  <= 1'b0;
                    r_clk2  <= 1'b0;
                    r_period_end <= 1'b0;
                end
            endcase
        end
    end

    assign o_clk1       = r_clk1;
    assign o_clk2       = r_clk2;
    assign o_period_end = r_period_end;
    assign o_run        = (r_state == PH_RUN);

endmodule

// File: rtl/mcs4_timing_sequencer.sv
// rtl/mcs4_timing_sequencer.sv - MCS-4 slot ring with master SYNC generation and slave SYNC lock
module mcs4_timing_sequencer
    import mcs4_timing_sequencer_pkg::*;
#(
    parameter int NUM_SLOTS = DEF_NUM_SLOTS,
    parameter int SYNC_SLOT = SLOT_X3,
    parameter int PH1_CYC   = DEF_PH1_CYC,
    parameter int PH2_CYC   = DEF_PH2_CYC,
    parameter int GAP_CYC   = DEF_GAP_CYC
) (
    input  logic                   sysclk,
    input  logic                   rst_n,
    mcs4_timing_sequencer_if.master bus
);

    localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    localparam logic [IDX_W-1:0] SYNC_IDX   = IDX_W'(SYNC_SLOT);
    localparam logic [IDX_W-1:0] RESYNC_IDX = IDX_W'((SYNC_SLOT + 1) % NUM_SLOTS);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_SLOTS - 1);

    generate
        if (NUM_SLOTS < 2) begin : g_bad_slots
            $error("NUM_SLOTS must be >= 2");
        end
        if ((SYNC_SLOT < 0) || (SYNC_SLOT >= NUM_SLOTS)) begin : g_bad_sync
            $error("SYNC_SLOT must be in 0..NUM_SLOTS-1");
        end
    endgenerate

    logic w_clk1;
    logic w_clk2;
    logic w_period_end;
    logic w_run;

    clock_phase_gen #(
        .PH1_CYC (PH1_CYC),
        .PH2_CYC (PH2_CYC),
        .GAP_CYC (GAP_CYC)
    ) u_phase (
        .i_clk        (sysclk),
        .i_rst_n      (rst_n),
        .i_enable     (bus.enable),
        .o_clk1       (w_clk1),
        .o_clk2       (w_clk2),
        .o_period_end (w_period_end),
        .o_run        (w_run)
    );

    logic [NUM_SLOTS-1:0] r_slot;
    logic [IDX_W-1:0]     r_slot_idx;
    logic                 r_sync_out;
    logic                 r_locked;
    logic                 r_resync_err;

    logic                 w_start;
    logic                 w_advance;
    logic                 w_at_sync;
    logic                 w_force;
    logic [IDX_W-1:0]     w_next_idx;
    logic [NUM_SLOTS-1:0] w_next_slot;

    // A SYNC seen in the wrong slot means the ring is out of step: jump to the slot after SYNC.
    always_comb begin
        w_start    = !w_run && bus.enable;
        w_advance  = w_period_end && bus.enable;
        w_at_sync  = (r_slot_idx == SYNC_IDX);
        w_force    = bus.slave_mode && bus.sync_in && !w_at_sync;
        w_next_idx = (r_slot_idx == LAST_IDX) ? '0 : (r_slot_idx + IDX_W'(1));
        if (w_force) begin
            w_next_idx = RESYNC_IDX;
        end
        w_next_slot = {{(NUM_SLOTS-1){1'b0}}, 1'b1} << w_next_idx;
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot       <= {{(NUM_SLOTS-1){1'b0}}, 1'b1};
            r_slot_idx   <= '0;
            r_sync_out   <= 1'b0;
            r_locked     <= 1'b0;
            r_resync_err <= 1'b0;
        end else begin
            r_resync_err <= 1'b0;
            if (w_advance) begin
                r_slot     <= w_next_slot;
                r_slot_idx <= w_next_idx;
            end
            if (!bus.slave_mode) begin
                if (w_start) begin
                    r_locked   <= 1'b1;
                    r_sync_out <= w_at_sync;
                end else if (w_advance) begin
                    r_sync_out <= (w_next_idx == SYNC_IDX);
                end
            end else begin
                r_sync_out <= 1'b0;
                // Lock bookkeeping runs at every period end, even when the ring parks.
                if (w_period_end) begin
                    if (bus.sync_in && w_at_sync) begin
                        r_locked <= 1'b1;
                    end else if (bus.sync_in) begin
                        r_locked     <= 1'b0;
                        r_resync_err <= r_locked;
                    end else if (w_at_sync && r_locked) begin
                        r_locked     <= 1'b0;
                        r_resync_err <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.clk1       = w_clk1;
    assign bus.clk2       = w_clk2;
    assign bus.slot       = r_slot;
    assign bus.slot_idx   = r_slot_idx;
    assign bus.sync_out   = r_sync_out;
    assign bus.locked     = r_locked;
    assign bus.resync_err = r_resync_err;

endmodule
